// File: rtl/iob_pcie_chnl_host.sv
// Host-side master for a RIFFA-style PCIe user channel: one RX transfer, then one TX reply per start.
// Define PCIE_HOST_TIMEOUT_EN to add a no-progress watchdog that aborts the exchange with an err pulse.
module iob_pcie_chnl_host #(
  parameter int DATA_W           = 32,
  parameter int C_PCI_DATA_WIDTH = 64,
  parameter int TIMEOUT_W        = 16
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        start,
  input  logic [DATA_W-1:0]           len,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [DATA_W-1:0]           tx_len_o,
  input  logic [C_PCI_DATA_WIDTH-1:0] src_data,
  input  logic                        src_valid,
  output logic                        src_ready,
  output logic [C_PCI_DATA_WIDTH-1:0] snk_data,
  output logic                        snk_valid,
  input  logic                        snk_ready,
  output logic                        chnl_rx,
  output logic                        chnl_rx_last,
  output logic [DATA_W-1:0]           chnl_rx_len,
  output logic [DATA_W-2:0]           chnl_rx_off,
  output logic [C_PCI_DATA_WIDTH-1:0] chnl_rx_data,
  output logic                        chnl_rx_data_valid,
  input  logic                        chnl_rx_ack,
  input  logic                        chnl_rx_data_ren,
  input  logic                        chnl_tx,
  input  logic                        chnl_tx_last,
  input  logic [DATA_W-1:0]           chnl_tx_len,
  input  logic [DATA_W-2:0]           chnl_tx_off,
  input  logic [C_PCI_DATA_WIDTH-1:0] chnl_tx_data,
  input  logic                        chnl_tx_data_valid,
  output logic                        chnl_tx_ack,
  output logic                        chnl_tx_data_ren
);

  localparam logic [DATA_W-1:0] WPB = DATA_W'(C_PCI_DATA_WIDTH / DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_REQ,
    S_RX_DATA,
    S_TX_WAIT,
    S_TX_DATA
  } state_t;

  state_t                        state, state_nxt;
  logic [DATA_W-1:0]             len_q, rcnt, tcnt, tx_len_q;
  logic [DATA_W-1:0]             rcnt_inc, tcnt_inc;
  logic [C_PCI_DATA_WIDTH-1:0]   snk_data_q;
  logic                          snk_valid_q, done_q, err_q;
  logic                          start_ok, rx_xfer, tx_accept, tx_xfer;
  logic                          done_nxt, err_nxt, progress;

  assign rcnt_inc = rcnt + WPB;
  assign tcnt_inc = tcnt + WPB;

`ifdef PCIE_HOST_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 abort;
`endif

  always_comb begin
    state_nxt          = state;
    chnl_rx            = 1'b0;
    chnl_rx_len        = '0;
    chnl_rx_data       = '0;
    chnl_rx_data_valid = 1'b0;
    src_ready          = 1'b0;
    chnl_tx_ack        = 1'b0;
    chnl_tx_data_ren   = 1'b0;
    start_ok           = 1'b0;
    rx_xfer            = 1'b0;
    tx_accept          = 1'b0;
    tx_xfer            = 1'b0;
    done_nxt           = 1'b0;
    err_nxt            = 1'b0;
    progress           = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            err_nxt = 1'b1;
          end else begin
            start_ok  = 1'b1;
            state_nxt = S_RX_REQ;
          end
        end
      end
      S_RX_REQ: begin
        chnl_rx  = 1'b1;
        progress = chnl_rx_ack;
        if (chnl_rx_ack) state_nxt = S_RX_DATA;
      end
      S_RX_DATA: begin
        chnl_rx            = 1'b1;
        chnl_rx_data       = src_data;
        chnl_rx_data_valid = src_valid;
        src_ready          = chnl_rx_data_ren;
        rx_xfer            = src_valid & chnl_rx_data_ren;
        progress           = rx_xfer;
        if (rx_xfer && (rcnt_inc >= len_q)) state_nxt = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        // The endpoint may raise chnl_tx early; it is only acknowledged here, after RX completes.
        chnl_tx_ack = chnl_tx;
        tx_accept   = chnl_tx;
        progress    = chnl_tx;
        if (chnl_tx) begin
          if (chnl_tx_len == '0) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_TX_DATA;
          end
        end
      end
      S_TX_DATA: begin
        // With snk_ready high the sink register drains this cycle, so it can take a new beat.
        chnl_tx_data_ren = snk_ready;
        tx_xfer          = chnl_tx_data_valid & snk_ready;
        progress         = tx_xfer;
        if (tx_xfer && (tcnt_inc >= tx_len_q)) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef PCIE_HOST_TIMEOUT_EN
    abort = (state != S_IDLE) && !progress && (wd_cnt == WD_LAST);
    if (abort) begin
      state_nxt          = S_IDLE;
      err_nxt            = 1'b1;
      done_nxt           = 1'b0;
      chnl_rx            = 1'b0;
      chnl_rx_data       = '0;
      chnl_rx_data_valid = 1'b0;
      src_ready          = 1'b0;
      chnl_tx_ack        = 1'b0;
      chnl_tx_data_ren   = 1'b0;
    end
`endif
    if (chnl_rx) chnl_rx_len = len_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      len_q       <= '0;
      rcnt        <= '0;
      tcnt        <= '0;
      tx_len_q    <= '0;
      snk_data_q  <= '0;
      snk_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      if (start_ok) begin
        len_q <= len;
        rcnt  <= '0;
      end
      if (rx_xfer) rcnt <= rcnt_inc;
      if (tx_accept) begin
        tx_len_q <= chnl_tx_len;
        tcnt     <= '0;
      end
      if (tx_xfer) begin
        tcnt        <= tcnt_inc;
        snk_data_q  <= chnl_tx_data;
        snk_valid_q <= 1'b1;
      end else if (snk_ready) begin
        snk_valid_q <= 1'b0;
      end
    end
  end

`ifdef PCIE_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wd_cnt <= '0;
    end else if ((state == S_IDLE) || progress || abort) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + TIMEOUT_W'(1);
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^{progress, (TIMEOUT_W > 0)};
`endif

  logic unused_in;
  assign unused_in = ^{chnl_tx_last, chnl_tx_off};

  assign busy         = (state != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign tx_len_o     = tx_len_q;
  assign snk_data     = snk_data_q;
  assign snk_valid    = snk_valid_q;
  assign chnl_rx_last = chnl_rx;
  assign chnl_rx_off  = '0;

endmodule
